rename_operand_stage: RTL



---
 rtl/rename_operand_stage_pkg.sv | 29 ++
 rtl/rename_operand_stage_operand_resolve.sv | 98 +++++++++
 rtl/rename_operand_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rename_operand_stage_pkg.sv
// Shared constants and types for the rename/operand stage.
// Default widths, bypass channel indices and the operand source encoding.
package rename_operand_stage_pkg;

    localparam int WORD_SIZE           = 32;
    localparam int ROB_ENTRY_WIDTH     = 3;
    localparam int NUM_ARCH_REGS       = 32;
    localparam int ARCH_REG_INDEX_SIZE = $clog2(NUM_ARCH_REGS);
    localparam int NUM_BYPASS_CH       = 6;

    // Default forwarding channel assignment (lower index wins on a tie)
    localparam int BYP_ALU    = 0;
    localparam int BYP_ALU_WB = 1;
    localparam int BYP_MEM    = 2;
    localparam int BYP_MEM_WB = 3;
    localparam int BYP_MUL    = 4;
    localparam int BYP_MUL_WB = 5;

    // Where a resolved operand came from
    typedef enum logic [2:0] {
        SRC_ZERO   = 3'd0,
        SRC_RF     = 3'd1,
        SRC_COMMIT = 3'd2,
        SRC_BYPASS = 3'd3,
        SRC_ROB    = 3'd4,
        SRC_WAIT   = 3'd5
    } src_sel_e;

endpackage

// File: rtl/rename_operand_stage_operand_resolve.sv
// Per-source operand priority mux: x0, register file, (optional commit
// forward), lowest-index bypass channel, ROB read port, else wait on tag.
// COMMIT_FORWARD_EN adds the same-cycle commit as a forwarding source.
module operand_resolve
    import rename_operand_stage_pkg::*;
#(
    parameter int WORD_SIZE       = 32,
    parameter int ROB_ENTRY_WIDTH = 3,
    parameter int REG_IDX         = 5,
    parameter int NUM_BYPASS      = 6
) (
    input  logic [REG_IDX-1:0]                    rs,
    input  logic [WORD_SIZE-1:0]                  rf_data,
    input  logic                                  rf_pending,
    input  logic [ROB_ENTRY_WIDTH-1:0]            rf_tag,
    input  logic [NUM_BYPASS-1:0]                 byp_valid,
    input  logic [NUM_BYPASS*ROB_ENTRY_WIDTH-1:0] byp_rob_id,
    input  logic [NUM_BYPASS*WORD_SIZE-1:0]       byp_data,
    input  logic                                  rob_valid,
    input  logic [WORD_SIZE-1:0]                  rob_data,
`ifdef COMMIT_FORWARD_EN
    input  logic                                  commit_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0]            commit_rob_id,
    input  logic [WORD_SIZE-1:0]                  commit_data,
`endif
    output logic [WORD_SIZE-1:0]                  op_data,
    output logic                                  op_ready,
    output logic [ROB_ENTRY_WIDTH-1:0]            op_tag
);

    logic [NUM_BYPASS-1:0] byp_hit;
    logic [WORD_SIZE-1:0]  byp_word [NUM_BYPASS];
    logic                  byp_any;
    logic [WORD_SIZE-1:0]  byp_sel_data;
    logic                  cmt_hit;
    src_sel_e              src_sel;

    // Unpack each channel and compare its tag against the source's tag
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYPASS; gi++) begin : g_byp
            assign byp_word[gi] = byp_data[gi*WORD_SIZE +: WORD_SIZE];
            assign byp_hit[gi]  = byp_valid[gi] &&
                                  (byp_rob_id[gi*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] == rf_tag);
        end
    endgenerate

`ifdef COMMIT_FORWARD_EN
    assign cmt_hit = commit_valid && (commit_rob_id == rf_tag);
`else
    assign cmt_hit = 1'b0;
`endif

    // Pick the lowest-index matching channel (scan high to low, last write wins)
    always_comb begin
        byp_any      = 1'b0;
        byp_sel_data = '0;
        for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
            if (byp_hit[i]) begin
                byp_any      = 1'b1;
                byp_sel_data = byp_word[i];
            end
        end
    end

    // Priority select of the operand source
    always_comb begin
        if (rs == '0)           src_sel = SRC_ZERO;
        else if (!rf_pending)   src_sel = SRC_RF;
        else if (cmt_hit)       src_sel = SRC_COMMIT;
        else if (byp_any)       src_sel = SRC_BYPASS;
        else if (rob_valid)     src_sel = SRC_ROB;
        else                    src_sel = SRC_WAIT;
    end

    // Drive value, readiness and wait tag from the selected source
    always_comb begin
        op_data  = '0;
        op_ready = 1'b1;
        op_tag   = '0;
        case (src_sel)
            SRC_ZERO:   op_data = '0;
            SRC_RF:     op_data = rf_data;
`ifdef COMMIT_FORWARD_EN
            SRC_COMMIT: op_data = commit_data;
`else
            SRC_COMMIT: op_data = '0;
`endif
            SRC_BYPASS: op_data = byp_sel_data;
            SRC_ROB:    op_data = rob_data;
            default: begin
                op_ready = 1'b0;
                op_tag   = rf_tag;
            end
        endcase
    end

endmodule

// File: rtl/rename_operand_stage.sv
// Rename/operand stage: architectural register file with per-register ROB
// tags, two operand resolvers and a stallable one-entry output register.
// Optional feature macro: COMMIT_FORWARD_EN (commit data forwarded to sources).
module rename_operand_stage #(
    parameter int WORD_SIZE       = rename_operand_stage_pkg::WORD_SIZE,
    parameter int NUM_REGS        = rename_operand_stage_pkg::NUM_ARCH_REGS,
    parameter int ROB_ENTRY_WIDTH = rename_operand_stage_pkg::ROB_ENTRY_WIDTH,
    parameter int NUM_BYPASS      = rename_operand_stage_pkg::NUM_BYPASS_CH,
    localparam int REG_IDX        = $clog2(NUM_REGS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [REG_IDX-1:0]                    rs1,
    input  logic [REG_IDX-1:0]                    rs2,
    input  logic [REG_IDX-1:0]                    rd,
    input  logic                                  rd_we,
    input  logic [ROB_ENTRY_WIDTH-1:0]            alloc_rob_id,
    output logic [ROB_ENTRY_WIDTH-1:0]            rob_s1_idx,
    output logic [ROB_ENTRY_WIDTH-1:0]            rob_s2_idx,
    input  logic                                  rob_s1_valid,
    input  logic                                  rob_s2_valid,
    input  logic [WORD_SIZE-1:0]                  rob_s1_data,
    input  logic [WORD_SIZE-1:0]                  rob_s2_data,
    input  logic [NUM_BYPASS-1:0]                 byp_valid,
    input  logic [NUM_BYPASS*ROB_ENTRY_WIDTH-1:0] byp_rob_id,
    input  logic [NUM_BYPASS*WORD_SIZE-1:0]       byp_data,
    input  logic                                  commit,
    input  logic [REG_IDX-1:0]                    commit_rd,
    input  logic [ROB_ENTRY_WIDTH-1:0]            commit_rob_id,
    input  logic [WORD_SIZE-1:0]                  commit_data,
    input  logic                                  jump_taken,
    input  logic                                  stall_in,
    output logic                                  out_valid,
    output logic [WORD_SIZE-1:0]                  s1_data,
    output logic [WORD_SIZE-1:0]                  s2_data,
    output logic                                  s1_ready,
    output logic                                  s2_ready,
    output logic [ROB_ENTRY_WIDTH-1:0]            s1_tag,
    output logic [ROB_ENTRY_WIDTH-1:0]            s2_tag,
    output logic [ROB_ENTRY_WIDTH-1:0]            out_rob_id
);

    import rename_operand_stage_pkg::*;

    // Architectural state
    logic [WORD_SIZE-1:0]       regs_q    [NUM_REGS];
    logic [WORD_SIZE-1:0]       regs_d    [NUM_REGS];
    logic [ROB_ENTRY_WIDTH-1:0] tag_q     [NUM_REGS];
    logic [ROB_ENTRY_WIDTH-1:0] tag_d     [NUM_REGS];
    logic [NUM_REGS-1:0]        pending_q;
    logic [NUM_REGS-1:0]        pending_d;

    // Output register
    logic                       out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0]       s1_data_q, s1_data_d;
    logic [WORD_SIZE-1:0]       s2_data_q, s2_data_d;
    logic                       s1_ready_q, s1_ready_d;
    logic                       s2_ready_q, s2_ready_d;
    logic [ROB_ENTRY_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic [ROB_ENTRY_WIDTH-1:0] s2_tag_q, s2_tag_d;
    logic [ROB_ENTRY_WIDTH-1:0] out_rob_id_q, out_rob_id_d;

    // Handshake
    logic hold;
    logic accept;
    logic rename_en;
    logic commit_en;

    // Resolver results
    logic [WORD_SIZE-1:0]       r1_data, r2_data;
    logic                       r1_ready, r2_ready;
    logic [ROB_ENTRY_WIDTH-1:0] r1_tag, r2_tag;

    assign hold      = stall_in && out_valid_q;
    assign in_ready  = !hold;
    assign accept    = in_valid && in_ready && !jump_taken;
    assign rename_en = accept && rd_we && (rd != '0);
    assign commit_en = commit && (commit_rd != '0);

    // The ROB is looked up with the pre-rename tag of each source
    assign rob_s1_idx = tag_q[rs1];
    assign rob_s2_idx = tag_q[rs2];

    operand_resolve #(
        .WORD_SIZE       (WORD_SIZE),
        .ROB_ENTRY_WIDTH (ROB_ENTRY_WIDTH),
        .REG_IDX         (REG_IDX),
        .NUM_BYPASS      (NUM_BYPASS)
    ) u_resolve_s1 (
        .rs            (rs1),
        .rf_data       (regs_q[rs1]),
        .rf_pending    (pending_q[rs1]),
        .rf_tag        (tag_q[rs1]),
        .byp_valid     (byp_valid),
        .byp_rob_id    (byp_rob_id),
        .byp_data      (byp_data),
        .rob_valid     (rob_s1_valid),
        .rob_data      (rob_s1_data),
`ifdef COMMIT_FORWARD_EN
        .commit_valid  (commit),
        .commit_rob_id (commit_rob_id),
        .commit_data   (commit_data),
`endif
        .op_data       (r1_data),
        .op_ready      (r1_ready),
        .op_tag        (r1_tag)
    );

    operand_resolve #(
        .WORD_SIZE       (WORD_SIZE),
        .ROB_ENTRY_WIDTH (ROB_ENTRY_WIDTH),
        .REG_IDX         (REG_IDX),
        .NUM_BYPASS      (NUM_BYPASS)
    ) u_resolve_s2 (
        .rs            (rs2),
        .rf_data       (regs_q[rs2]),
        .rf_pending    (pending_q[rs2]),
        .rf_tag        (tag_q[rs2]),
        .byp_valid     (byp_valid),
        .byp_rob_id    (byp_rob_id),
        .byp_data      (byp_data),
        .rob_valid     (rob_s2_valid),
        .rob_data      (rob_s2_data),
`ifdef COMMIT_FORWARD_EN
        .commit_valid  (commit),
        .commit_rob_id (commit_rob_id),
        .commit_data   (commit_data),
`endif
        .op_data       (r2_data),
        .op_ready      (r2_ready),
        .op_tag        (r2_tag)
    );

    // Next architectural state: commit write, flush, then rename (rename wins)
    always_comb begin
        regs_d    = regs_q;
        tag_d     = tag_q;
        pending_d = pending_q;
        if (commit_en) begin
            regs_d[commit_rd] = commit_data;
            if (tag_q[commit_rd] == commit_rob_id) begin
                pending_d[commit_rd] = 1'b0;
            end
        end
        if (jump_taken) begin
            pending_d = '0;
        end
        if (rename_en) begin
            pending_d[rd] = 1'b1;
            tag_d[rd]     = alloc_rob_id;
        end
    end

    // Next output register: load on accept, hold under stall, drop on flush
    always_comb begin
        s1_data_d    = s1_data_q;
        s2_data_d    = s2_data_q;
        s1_ready_d   = s1_ready_q;
        s2_ready_d   = s2_ready_q;
        s1_tag_d     = s1_tag_q;
        s2_tag_d     = s2_tag_q;
        out_rob_id_d = out_rob_id_q;
        if (jump_taken) begin
            out_valid_d = 1'b0;
        end else if (hold) begin
            out_valid_d = out_valid_q;
        end else begin
            out_valid_d = accept;
        end
        if (accept) begin
            s1_data_d    = r1_data;
            s2_data_d    = r2_data;
            s1_ready_d   = r1_ready;
            s2_ready_d   = r2_ready;
            s1_tag_d     = r1_tag;
            s2_tag_d     = r2_tag;
            out_rob_id_d = alloc_rob_id;
        end
    end

    // Architectural state registers; x0 is pinned to zero and never pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
                tag_q[i]  <= tag_d[i];
            end
            regs_q[0]    <= '0;
            tag_q[0]     <= '0;
            pending_q    <= pending_d;
            pending_q[0] <= 1'b0;
        end
    end

    // Output stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            s1_data_q    <= '0;
            s2_data_q    <= '0;
            s1_ready_q   <= 1'b0;
            s2_ready_q   <= 1'b0;
            s1_tag_q     <= '0;
            s2_tag_q     <= '0;
            out_rob_id_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            s1_data_q    <= s1_data_d;
            s2_data_q    <= s2_data_d;
            s1_ready_q   <= s1_ready_d;
            s2_ready_q   <= s2_ready_d;
            s1_tag_q     <= s1_tag_d;
            s2_tag_q     <= s2_tag_d;
            out_rob_id_q <= out_rob_id_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign s1_data    = s1_data_q;
    assign s2_data    = s2_data_q;
    assign s1_ready   = s1_ready_q;
    assign s2_ready   = s2_ready_q;
    assign s1_tag     = s1_tag_q;
    assign s2_tag     = s2_tag_q;
    assign out_rob_id = out_rob_id_q;

endmodule
